// File: rtl/nest_block_checker_pkg.sv
// Shared definitions for the nested block keyword checker: ASCII delimiters,
// keyword classes, error encodings and small character helpers.
package nest_block_checker_pkg;

    localparam logic [7:0] SP  = 8'h20;
    localparam logic [7:0] TAB = 8'h09;
    localparam logic [7:0] LF  = 8'h0A;
    localparam logic [7:0] CR  = 8'h0D;

    typedef enum logic [2:0] {
        KW_NONE,
        KW_OPEN_B,
        KW_OPEN_F,
        KW_CLOSE_B,
        KW_CLOSE_F
    } kw_class_e;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_UNDERFLOW = 2'b01;
    localparam logic [1:0] ERR_MISMATCH  = 2'b10;
    localparam logic [1:0] ERR_OVERFLOW  = 2'b11;

    // Stack entry encoding for the block kind
    localparam logic BLK_B = 1'b0;
    localparam logic BLK_F = 1'b1;

    function automatic logic is_delim(input logic [7:0] ch, input logic ws_ext);
        return (ch == SP) || (ws_ext && ((ch == TAB) || (ch == LF) || (ch == CR)));
    endfunction

    function automatic logic [7:0] fold_case(input logic [7:0] ch, input logic case_ins);
        if (case_ins && (ch >= 8'h41) && (ch <= 8'h5A))
            return ch | 8'h20;
        return ch;
    endfunction

endpackage

// File: rtl/nbc_kw_matcher.sv
// Per-word keyword recogniser: walks the characters of one word and reports
// the tentative keyword class, which holds only while the word is an exact keyword.
module nbc_kw_matcher
    import nest_block_checker_pkg::*;
#(
    parameter bit CASE_INS = 1'b1,
    parameter bit WS_EXT   = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ch,
    input  logic       valid,
    output kw_class_e  kw_class
);

    typedef enum logic [4:0] {
        S_IDLE,
        S_B, S_BE, S_BEG, S_BEGI, S_MATCH_BEGIN,
        S_F, S_FO, S_FOR, S_MATCH_FORK,
        S_E, S_EN, S_MATCH_END,
        S_J, S_JO, S_JOI, S_MATCH_JOIN,
        S_DEAD
    } state_e;

    state_e     state_q;
    state_e     state_d;
    kw_class_e  class_d;
    logic [7:0] ch_f;
    logic       delim;

    assign ch_f  = fold_case(ch, CASE_INS);
    assign delim = is_delim(ch, WS_EXT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            kw_class <= KW_NONE;
        end else begin
            state_q  <= state_d;
            kw_class <= class_d;
        end
    end

    // Any character that does not extend a keyword prefix sends the word to DEAD
    always_comb begin
        state_d = state_q;
        class_d = kw_class;
        if (valid) begin
            class_d = KW_NONE;
            if (delim) begin
                state_d = S_IDLE;
            end else begin
                state_d = S_DEAD;
                case (state_q)
                    S_IDLE: begin
                        if (ch_f == "b")      state_d = S_B;
                        else if (ch_f == "f") state_d = S_F;
                        else if (ch_f == "e") state_d = S_E;
                        else if (ch_f == "j") state_d = S_J;
                    end
                    S_B:    if (ch_f == "e") state_d = S_BE;
                    S_BE:   if (ch_f == "g") state_d = S_BEG;
                    S_BEG:  if (ch_f == "i") state_d = S_BEGI;
                    S_BEGI: if (ch_f == "n") begin
                        state_d = S_MATCH_BEGIN;
                        class_d = KW_OPEN_B;
                    end
                    S_F:    if (ch_f == "o") state_d = S_FO;
                    S_FO:   if (ch_f == "r") state_d = S_FOR;
                    S_FOR:  if (ch_f == "k") begin
                        state_d = S_MATCH_FORK;
                        class_d = KW_OPEN_F;
                    end
                    S_E:    if (ch_f == "n") state_d = S_EN;
                    S_EN:   if (ch_f == "d") begin
                        state_d = S_MATCH_END;
                        class_d = KW_CLOSE_B;
                    end
                    S_J:    if (ch_f == "o") state_d = S_JO;
                    S_JO:   if (ch_f == "i") state_d = S_JOI;
                    S_JOI:  if (ch_f == "n") begin
                        state_d = S_MATCH_JOIN;
                        class_d = KW_CLOSE_F;
                    end
                    default: state_d = S_DEAD;
                endcase
            end
        end
    end

endmodule

// File: rtl/nest_block_checker.sv
// Streaming begin/end and fork/join nesting checker. Committed stack state is
// updated on delimiters; outputs show committed state with the current word applied.
module nest_block_checker
    import nest_block_checker_pkg::*;
#(
    parameter int unsigned MAX_DEPTH = 8,
    parameter int unsigned DW        = 4,
    parameter bit          CASE_INS  = 1'b1,
    parameter bit          WS_EXT    = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    in,
    input  logic          in_valid,
    output logic          result,
    output logic [DW-1:0] depth,
    output logic [1:0]    err_code
);

    logic [MAX_DEPTH-1:0] stack_q;
    logic [DW-1:0]        depth_q;
    logic [1:0]           err_q;

    logic [MAX_DEPTH-1:0] stack_eff;
    logic [DW-1:0]        depth_eff;
    logic [1:0]           err_eff;

    kw_class_e            tent;
    logic                 blk;
    logic                 top_type;

    nbc_kw_matcher #(
        .CASE_INS (CASE_INS),
        .WS_EXT   (WS_EXT)
    ) u_matcher (
        .clk      (clk),
        .reset    (reset),
        .ch       (in),
        .valid    (in_valid),
        .kw_class (tent)
    );

    assign blk = ((tent == KW_OPEN_F) || (tent == KW_CLOSE_F)) ? BLK_F : BLK_B;

    // Entry at index depth-1 is the innermost open block
    always_comb begin
        top_type = BLK_B;
        for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
            if (DW'(i + 1) == depth_q)
                top_type = stack_q[i];
        end
    end

    // Apply the tentative keyword; errors are trapped before depth can wrap
    always_comb begin
        stack_eff = stack_q;
        depth_eff = depth_q;
        err_eff   = err_q;
        if (err_q == ERR_NONE) begin
            case (tent)
                KW_OPEN_B, KW_OPEN_F: begin
                    if (depth_q == DW'(MAX_DEPTH)) begin
                        err_eff = ERR_OVERFLOW;
                    end else begin
                        for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
                            if (DW'(i) == depth_q)
                                stack_eff[i] = blk;
                        end
                        depth_eff = depth_q + DW'(1);
                    end
                end
                KW_CLOSE_B, KW_CLOSE_F: begin
                    if (depth_q == '0)
                        err_eff = ERR_UNDERFLOW;
                    else if (top_type != blk)
                        err_eff = ERR_MISMATCH;
                    else
                        depth_eff = depth_q - DW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stack_q <= '0;
            depth_q <= '0;
            err_q   <= ERR_NONE;
        end else if (in_valid && is_delim(in, WS_EXT)) begin
            stack_q <= stack_eff;
            depth_q <= depth_eff;
            err_q   <= err_eff;
        end
    end

    assign result   = (depth_eff == '0) && (err_eff == ERR_NONE);
    assign depth    = depth_eff;
    assign err_code = err_eff;

endmodule

// File: tb/tb_nest_block_checker.sv
// Scoreboard bench: two checker configurations share one character stream and are
// compared every cycle against a word-level reference model.
module tb_nest_block_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ch_in = 8'h00;
    logic       ch_valid = 1'b0;

    logic       r0, r1;
    logic [3:0] d0;
    logic [2:0] d1;
    logic [1:0] e0, e1;

    always #5 clk = ~clk;

    nest_block_checker #(.MAX_DEPTH(8), .DW(4), .CASE_INS(1'b1), .WS_EXT(1'b0)) dut0 (
        .clk(clk), .reset(reset), .in(ch_in), .in_valid(ch_valid),
        .result(r0), .depth(d0), .err_code(e0));

    nest_block_checker #(.MAX_DEPTH(4), .DW(3), .CASE_INS(1'b0), .WS_EXT(1'b1)) dut1 (
        .clk(clk), .reset(reset), .in(ch_in), .in_valid(ch_valid),
        .result(r1), .depth(d1), .err_code(e1));

    // Reference model: committed stack per configuration plus the raw current word
    int  maxd [2] = '{8, 4};
    bit  ci   [2] = '{1'b1, 1'b0};
    bit  wx   [2] = '{1'b0, 1'b1};
    bit  mstk [2][16];
    int  mdep [2] = '{0, 0};
    int  merr [2] = '{0, 0};
    byte wbuf [2][8];
    int  wlen [2] = '{0, 0};

    typedef struct {
        int c;
        bit res;
        int dep;
        int err;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic bit kw_is(int c, string k);
        byte x;
        if (wlen[c] != k.len()) return 1'b0;
        for (int i = 0; i < wlen[c]; i++) begin
            x = wbuf[c][i];
            if (ci[c] && x >= 8'h41 && x <= 8'h5A) x = x + 8'h20;
            if (x != k.getc(i)) return 1'b0;
        end
        return 1'b1;
    endfunction

    // 0 none, 1 open begin, 2 open fork, 3 close end, 4 close join
    function automatic int classify(int c);
        if (kw_is(c, "begin")) return 1;
        if (kw_is(c, "fork"))  return 2;
        if (kw_is(c, "end"))   return 3;
        if (kw_is(c, "join"))  return 4;
        return 0;
    endfunction

    task automatic eff(input int c, output int d, output int e, output int k);
        d = mdep[c];
        e = merr[c];
        k = classify(c);
        if (e != 0) return;
        if (k == 1 || k == 2) begin
            if (d == maxd[c]) e = 3;
            else d = d + 1;
        end else if (k == 3 || k == 4) begin
            if (d == 0) e = 1;
            else if (mstk[c][d-1] != (k == 4)) e = 2;
            else d = d - 1;
        end
    endtask

    task automatic model_char(byte ch);
        int d, e, k;
        bit delim;
        for (int c = 0; c < 2; c++) begin
            delim = (ch == 8'h20) || (wx[c] && (ch == 8'h09 || ch == 8'h0A || ch == 8'h0D));
            if (delim) begin
                eff(c, d, e, k);
                if (merr[c] == 0 && e == 0 && (k == 1 || k == 2))
                    mstk[c][mdep[c]] = (k == 2);
                mdep[c] = d;
                merr[c] = e;
                wlen[c] = 0;
            end else begin
                if (wlen[c] < 8) wbuf[c][wlen[c]] = ch;
                wlen[c]++;
            end
        end
    endtask

    task automatic push_exp();
        int d, e, k;
        exp_t x;
        for (int c = 0; c < 2; c++) begin
            eff(c, d, e, k);
            x.c = c;
            x.dep = d;
            x.err = e;
            x.res = (d == 0) && (e == 0);
            exp_q.push_back(x);
        end
    endtask

    task automatic send(byte ch);
        @(negedge clk);
        reset = 1'b0;
        ch_in = ch;
        ch_valid = 1'b1;
        model_char(ch);
        push_exp();
    endtask

    task automatic gap();
        @(negedge clk);
        reset = 1'b0;
        ch_valid = 1'b0;
        ch_in = 8'($urandom);
        push_exp();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        ch_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            mdep[c] = 0;
            merr[c] = 0;
            wlen[c] = 0;
        end
        push_exp();
    endtask

    task automatic send_str(string s);
        for (int i = 0; i < s.len(); i++) begin
            send(s.getc(i));
            if ($urandom_range(3) == 0) gap();
        end
    endtask

    // Monitor: checks every expectation issued for the edge just taken
    initial begin
        exp_t x;
        bit   ar;
        int   ad, ae;
        forever begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                ar = (x.c == 0) ? r0 : r1;
                ad = (x.c == 0) ? int'(d0) : int'(d1);
                ae = (x.c == 0) ? int'(e0) : int'(e1);
                checks++;
                if (ar != x.res || ad != x.dep || ae != x.err) begin
                    errors++;
                    $display("FAIL cfg%0d outputs @%0t: got result=%0b depth=%0d err=%0d, want result=%0b depth=%0d err=%0d",
                             x.c, $time, ar, ad, ae, x.res, x.dep, x.err);
                end
            end
        end
    end

    string toks [10] = '{"begin", "end", "fork", "join", "BeGiN", "FORK", "beg", "endx", "x", "in"};
    byte   dels [4]  = '{8'h20, 8'h09, 8'h0A, 8'h0D};

    initial begin
        string t;
        do_reset();
        send_str("begin end ");
        do_reset();
        send_str("end begin end ");
        do_reset();
        send_str("fork end ");
        do_reset();
        send_str("fork join ");
        do_reset();
        send_str("beginx end ");
        do_reset();
        send_str("fork fork fork fork fork ");
        do_reset();
        send_str("beg");
        do_reset();
        send_str("in ");
        send_str("BeGiN ");
        do_reset();
        send_str("fork\tbegin\nend\rjoin join ");

        for (int r = 0; r < 500; r++) begin
            if ($urandom_range(24) == 0) do_reset();
            t = toks[$urandom_range(9)];
            for (int i = 0; i < t.len(); i++) begin
                send(t.getc(i));
                if ($urandom_range(5) == 0) gap();
                if ($urandom_range(60) == 0) do_reset();
            end
            send(dels[$urandom_range(3)]);
            if ($urandom_range(7) == 0) send(8'h20);
        end

        gap();
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
